// File: rtl/adder_pkg.sv
// Shared limb constants and the serial adder's state encoding.
package adder_pkg;

    localparam int LIMB_W = 64;
    localparam logic [LIMB_W-1:0] LIMB_ONES = {LIMB_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : adder_pkg

// File: rtl/sparse_adder64.sv
// Combinational 64-bit sparse-tree adder.
// A Kogge-Stone prefix over 4-bit groups yields one carry per group.
// Each group then ripples its own four sum bits from that carry.
module sparse_adder64
    import adder_pkg::*;
(
    input  logic [LIMB_W-1:0] a_i,
    input  logic [LIMB_W-1:0] b_i,
    output logic [LIMB_W-1:0] sum_o,
    output logic              co_o
);

    function automatic logic [LIMB_W:0] sparse_add(input logic [LIMB_W-1:0] a,
                                                   input logic [LIMB_W-1:0] b);
        logic [LIMB_W-1:0] g;
        logic [LIMB_W-1:0] p;
        logic [LIMB_W-1:0] s;
        logic [15:0]       gg;
        logic [15:0]       gp;
        logic [15:0]       ng;
        logic [15:0]       np;
        logic [15:0]       cin;
        logic              c;
        g = a & b;
        p = a ^ b;
        for (int k = 0; k < 16; k++) begin
            gg[k] = 1'b0;
            gp[k] = 1'b1;
            for (int j = 0; j < 4; j++) begin
                gg[k] = g[4*k+j] | (p[4*k+j] & gg[k]);
                gp[k] = gp[k] & p[4*k+j];
            end
        end
        for (int d = 1; d < 16; d = d * 2) begin
            ng = gg;
            np = gp;
            for (int k = d; k < 16; k++) begin
                ng[k] = gg[k] | (gp[k] & gg[k-d]);
                np[k] = gp[k] & gp[k-d];
            end
            gg = ng;
            gp = np;
        end
        cin = {gg[14:0], 1'b0};
        for (int k = 0; k < 16; k++) begin
            c = cin[k];
            for (int j = 0; j < 4; j++) begin
                s[4*k+j] = p[4*k+j] ^ c;
                c = g[4*k+j] | (p[4*k+j] & c);
            end
        end
        return {gg[15], s};
    endfunction

    assign {co_o, sum_o} = sparse_add(a_i, b_i);

endmodule : sparse_adder64

// File: rtl/limb_serial_adder.sv
// Wide add/subtract, one 64-bit limb per cycle through a single sparse adder.
//
// state | meaning
// IDLE  | waiting for a request; in_ready high
// RUN   | one limb per cycle, carry chained in carry_q
// DONE  | result presented until out_ready
//
// The adder's B input is B_limb + carry, so a wrap of that increment
// (B_limb all ones with carry set) is folded back into the carry here.
module limb_serial_adder
    import adder_pkg::*;
#(
    parameter  int N_LIMBS = 4,
    localparam int W       = LIMB_W * N_LIMBS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_co,
    output logic         out_zero
);

    localparam int IDX_W = (N_LIMBS > 1) ? $clog2(N_LIMBS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LIMBS - 1);

    typedef logic [N_LIMBS-1:0][LIMB_W-1:0] limbs_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    limbs_t           a_q, a_d;
    limbs_t           b_q, b_d;
    limbs_t           sum_q, sum_d;
    logic             co_q, co_d;
    logic             zero_q, zero_d;

    logic [LIMB_W-1:0] a_limb;
    logic [LIMB_W-1:0] b_limb;
    logic [LIMB_W-1:0] bx;
    logic [LIMB_W-1:0] add_sum;
    logic              add_co;
    logic              carry_nxt;

    assign a_limb    = a_q[idx_q];
    assign b_limb    = b_q[idx_q];
    assign bx        = b_limb + {{(LIMB_W-1){1'b0}}, carry_q};
    assign carry_nxt = add_co | (carry_q & (b_limb == LIMB_ONES));

    sparse_adder64 u_add (
        .a_i   (a_limb),
        .b_i   (bx),
        .sum_o (add_sum),
        .co_o  (add_co)
    );

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_co    = co_q;
    assign out_zero  = zero_q;

    // Next-state: capture operands, step through limbs, hold the result.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        co_d    = co_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = in_a;
                    b_d     = in_sub ? ~in_b : in_b;
                    carry_d = in_sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q] = add_sum;
                carry_d      = carry_nxt;
                idx_d        = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    co_d    = carry_nxt;
                    zero_d  = (sum_d == '0);
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            zero_q  <= zero_d;
        end
    end

endmodule : limb_serial_adder

// File: tb/tb_limb_serial_adder.sv
// Scoreboard bench for limb_serial_adder: the driver pushes expected results
// at acceptance, a monitor pops and compares on every output handshake.
module tb_limb_serial_adder;

    localparam int N = 4;
    localparam int W = 64 * N;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_co;
    logic         out_zero;

    logic rand_mode = 1'b0;
    logic rnd_rdy   = 1'b0;
    logic rdy_force = 1'b1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         co;
        logic         zero;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] s;
        logic         co;
        logic         z;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[10];

    always #5 clk = ~clk;

    assign out_ready = rand_mode ? rnd_rdy : rdy_force;

    always @(posedge clk) #1 rnd_rdy = 1'($urandom_range(0, 1));

    limb_serial_adder #(.N_LIMBS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_co    (out_co),
        .out_zero  (out_zero)
    );

    task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        logic [W:0] r;
        exp_t e;
        r = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{W{1'b0}}, sub};
        e.sum  = r[W-1:0];
        e.co   = r[W];
        e.zero = (r[W-1:0] == '0);
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] v;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
                0:       v[64*i +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
                1:       v[64*i +: 64] = 64'h0;
                default: v[64*i +: 64] = {$urandom, $urandom};
            endcase
        end
        return v;
    endfunction

    // Monitor: compare every output handshake against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk1("unexpected_out_valid", out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chkw("out_sum", out_sum, e.sum);
                    chk1("out_co", out_co, e.co);
                    chk1("out_zero", out_zero, e.zero);
                end
            end
        end
    end

    // Issue one request at posedge+1 phase; returns 1 time unit after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input exp_t e, input bit push);
        int waitc;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_valid = 1'b1;
        waitc    = 0;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            waitc++;
            if (waitc > 200) begin
                chk1("accept_timeout", in_ready, 1'b1);
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        in_b     = ~in_a;
        in_sub   = ~sub;
        if (push) exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 2000) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk_int("drain_pending", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   k;
        bit   seen;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;

        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 256'h1, 1'b0, 256'h1 << 64, 1'b0, 1'b0};
        vecs[1] = '{256'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        vecs[2] = '{256'h1, (256'h1 << 128) - 256'h1, 1'b0, 256'h1 << 128, 1'b0, 1'b0};
        vecs[3] = '{256'h7, 256'h5, 1'b1, 256'h2, 1'b1, 1'b0};
        vecs[4] = '{256'h5, 256'h7, 1'b1, ~256'h1, 1'b0, 1'b0};
        vecs[5] = '{256'h9, 256'h9, 1'b1, 256'h0, 1'b1, 1'b1};
        vecs[6] = '{256'h0, 256'h0, 1'b0, 256'h0, 1'b0, 1'b1};
        vecs[7] = '{ONES, ONES, 1'b0, ~256'h1, 1'b1, 1'b0};
        vecs[8] = '{256'd123, 256'h0, 1'b1, 256'd123, 1'b1, 1'b0};
        vecs[9] = '{256'h1 << 64, 256'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        rdy_force = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_out_co", out_co, 1'b0);
        chk1("rst_out_zero", out_zero, 1'b0);
        chkw("rst_out_sum", out_sum, '0);
        rst_n = 1'b1;
        #1;
        chk1("post_rst_in_ready", in_ready, 1'b1);

        // Full carry ripple, plus exact latency from acceptance to out_valid.
        e = '{256'h0, 1'b1, 1'b1};
        send(ONES, 256'h1, 1'b0, e, 1'b1);
        chk1("no_back_to_back", in_ready, 1'b0);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 50) begin
            @(posedge clk);
            #1;
            k++;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        chk_int("latency", k, N);
        wait_drain();

        for (int i = 0; i < 10; i++) begin
            e = '{vecs[i].s, vecs[i].co, vecs[i].z};
            send(vecs[i].a, vecs[i].b, vecs[i].sub, e, 1'b1);
        end
        wait_drain();

        // Backpressure: result held for 10 cycles, then released.
        rdy_force = 1'b0;
        e = '{256'd158, 1'b0, 1'b0};
        send(256'd100, 256'd58, 1'b0, e, 1'b1);
        k = 0;
        while (out_valid !== 1'b1 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk1("bp_out_valid_rise", out_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk1("bp_out_valid_hold", out_valid, 1'b1);
            chkw("bp_out_sum_hold", out_sum, 256'd158);
            chk1("bp_out_co_hold", out_co, 1'b0);
            chk1("bp_out_zero_hold", out_zero, 1'b0);
            chk1("bp_in_ready_low", in_ready, 1'b0);
        end
        rdy_force = 1'b1;
        @(posedge clk);
        #1;
        chk1("release_in_ready", in_ready, 1'b1);
        chk1("release_out_valid", out_valid, 1'b0);
        chkw("idle_keeps_sum", out_sum, 256'd158);
        chk_int("bp_popped", exp_q.size(), 0);

        // Reset during RUN at limb index 2: request is dropped.
        e = '{256'h0, 1'b0, 1'b0};
        send(256'd5, 256'd3, 1'b0, e, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("abort_in_ready_during_rst", in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk1("abort_in_ready", in_ready, 1'b1);
        chkw("abort_out_sum", out_sum, '0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        chk1("abort_no_out_valid", seen, 1'b0);

        // Random requests with random gaps and random out_ready.
        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            a   = rnd_op();
            b   = rnd_op();
            sub = 1'($urandom_range(0, 1));
            send(a, b, sub, model(a, b, sub), 1'b1);
        end
        wait_drain();
        rand_mode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_limb_serial_adder
